// File: rtl/systolic_pkg.sv
// systolic_pkg
// Shared definitions for the systolic array feeder slice: default array
// dimensions, the operand element type, the feeder FSM state encoding and
// the feed sequence length helper.
package systolic_pkg;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 4;

  typedef logic [DW_DEF-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    DONE = 2'd2
  } feed_state_t;

  // Number of FEED cycles for an n x n array: 2n-1 cycles of skewed data
  // followed by n-1 cycles of zero flush.
  function automatic int feed_len(input int n);
    return 3 * n - 2;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_lane.sv
// skew_lane
// One lane of the skewed wavefront. Given the feed cycle t and this lane's
// index LANE, it emits element (t - LANE) of the stored N-element vector.
// When t - LANE falls outside 0..N-1 it emits zero.
// Ports:
//   t_i     feed cycle counter value
//   vec_i   stored row/column, element k in bits [k*DW +: DW]
//   elem_o  selected element, or zero outside the window
module skew_lane
  import systolic_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int DW   = DW_DEF,
  parameter int CW   = 4,
  parameter int LANE = 0
) (
  input  logic [CW-1:0]   t_i,
  input  logic [N*DW-1:0] vec_i,
  output logic [DW-1:0]   elem_o
);

  int rel;

  // The offset is computed as a signed integer so that cycles before this
  // lane's window opens (t < LANE) go negative and simply match no element.
  // Cycles past the window exceed N-1 and likewise match nothing, leaving
  // the zero default on the output.
  always_comb begin
    rel    = int'(t_i) - LANE;
    elem_o = '0;
    for (int k = 0; k < N; k++) begin
      if (rel == k) begin
        elem_o = vec_i[k*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
// Upstream feeder for an N x N systolic multiply array. Operand matrix A is
// written row by row and matrix B column by column into local buffers. On
// start the block streams the diagonally skewed wavefront onto the array's
// left edge (A rows) and top edge (B columns), flushes with zeros so the last
// operands traverse every PE, then pulses done. Data is passed unmodified.
// Ports:
//   clk_i, rst_i   clock (rising edge), asynchronous active-high reset
//   wr_valid_i     operand write request
//   wr_ready_o     high when a write would be accepted (IDLE only)
//   wr_sel_i       0 = A row, 1 = B column
//   wr_idx_i       row (A) or column (B) index; indices >= N are dropped
//   wr_data_i      element k in bits [k*DW +: DW]
//   start_i        begin a feed sequence, honoured in IDLE only
//   busy_o         high during FEED
//   left_o         lane i drives the left input of array row i
//   top_o          lane j drives the top input of array column j
//   feed_valid_o   high on every FEED cycle, including the flush
//   done_o         single-cycle pulse after the last flush cycle
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int IW = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_valid_i,
  output logic            wr_ready_o,
  input  logic            wr_sel_i,
  input  logic [IW-1:0]   wr_idx_i,
  input  logic [N*DW-1:0] wr_data_i,
  input  logic            start_i,
  output logic            busy_o,
  output logic [N*DW-1:0] left_o,
  output logic [N*DW-1:0] top_o,
  output logic            feed_valid_o,
  output logic            done_o
);

  localparam int CW = $clog2(feed_len(N));
  localparam logic [CW-1:0] T_LAST = CW'(feed_len(N) - 1);

  feed_state_t     state_q, state_d;
  logic [CW-1:0]   t_q, t_d;
  logic [N*DW-1:0] a_q [N];
  logic [N*DW-1:0] a_d [N];
  logic [N*DW-1:0] b_q [N];
  logic [N*DW-1:0] b_d [N];
  logic            wr_en;
  logic            feed_d;
  logic [N*DW-1:0] left_d, top_d;

  // A write is taken only while ready (IDLE) and only for an index that
  // names a real row/column; out-of-range indices leave the buffers alone.
  assign wr_en = wr_valid_i & wr_ready_o & ({1'b0, wr_idx_i} < (IW+1)'(N));

  // Next-state view of the operand buffers. The lanes read this view rather
  // than the registered copy so that a write landing on the same edge as
  // start is already visible in the first feed cycle.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    for (int r = 0; r < N; r++) begin
      if (wr_en && (wr_idx_i == IW'(r))) begin
        if (wr_sel_i) begin
          b_d[r] = wr_data_i;
        end else begin
          a_d[r] = wr_data_i;
        end
      end
    end
  end

  // Sequencer: IDLE waits for start, FEED walks t from 0 to 3N-3, DONE lasts
  // exactly one cycle. start outside IDLE is dropped rather than remembered.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FEED;
          t_d     = '0;
        end
      end
      FEED: begin
        if (t_q == T_LAST) begin
          state_d = DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  assign feed_d = (state_d == FEED);

  // One skew lane per array row (fed from A rows) and one per array column
  // (fed from B columns). Lane g of either edge is delayed by g cycles.
  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_lane #(.N(N), .DW(DW), .CW(CW), .LANE(g)) u_left (
      .t_i    (t_d),
      .vec_i  (a_d[g]),
      .elem_o (left_d[g*DW +: DW])
    );
    skew_lane #(.N(N), .DW(DW), .CW(CW), .LANE(g)) u_top (
      .t_i    (t_d),
      .vec_i  (b_d[g]),
      .elem_o (top_d[g*DW +: DW])
    );
  end

  // FSM state and feed cycle counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  // Operand buffers. They are cleared only by reset and otherwise keep their
  // contents across feeds, so a second start replays the same streams.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < N; r++) begin
        a_q[r] <= '0;
        b_q[r] <= '0;
      end
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  // Registered outputs, decoded from the state being entered. Outside FEED
  // both edges are forced to zero so the array accumulates nothing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      left_o       <= '0;
      top_o        <= '0;
      feed_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      wr_ready_o   <= 1'b1;
    end else begin
      left_o       <= feed_d ? left_d : '0;
      top_o        <= feed_d ? top_d : '0;
      feed_valid_o <= feed_d;
      busy_o       <= feed_d;
      done_o       <= (state_d == DONE);
      wr_ready_o   <= (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder
// Bench for systolic_skew_feeder. A directed N=2 instance checks the exact
// wavefront table and the write/start collision; an N=4 instance is driven
// with random operands and compared against a matrix model that computes the
// skewed streams directly from A and B.
module tb_systolic_skew_feeder;
  import systolic_pkg::*;

  localparam int FL4 = 10;

  logic clk_i = 1'b0;
  logic rst_i;

  logic        wr_valid, wr_ready, wr_sel, start, busy, feed_valid, done;
  logic [2:0]  wr_idx;
  logic [15:0] wr_data, left_out, top_out;

  logic        d2_wr_valid, d2_wr_ready, d2_wr_sel, d2_start, d2_busy;
  logic        d2_feed_valid, d2_done;
  logic [2:0]  d2_wr_idx;
  logic [7:0]  d2_wr_data, d2_left, d2_top;

  logic [3:0]  model_a [4][4];
  logic [3:0]  model_b [4][4];

  int tests_run = 0;
  int tests_failed = 0;

  systolic_skew_feeder #(.N(4), .DW(4), .IW(3)) dut4 (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wr_valid_i   (wr_valid),
    .wr_ready_o   (wr_ready),
    .wr_sel_i     (wr_sel),
    .wr_idx_i     (wr_idx),
    .wr_data_i    (wr_data),
    .start_i      (start),
    .busy_o       (busy),
    .left_o       (left_out),
    .top_o        (top_out),
    .feed_valid_o (feed_valid),
    .done_o       (done)
  );

  systolic_skew_feeder #(.N(2), .DW(4), .IW(3)) dut2 (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wr_valid_i   (d2_wr_valid),
    .wr_ready_o   (d2_wr_ready),
    .wr_sel_i     (d2_wr_sel),
    .wr_idx_i     (d2_wr_idx),
    .wr_data_i    (d2_wr_data),
    .start_i      (d2_start),
    .busy_o       (d2_busy),
    .left_o       (d2_left),
    .top_o        (d2_top),
    .feed_valid_o (d2_feed_valid),
    .done_o       (d2_done)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic applyStimulus(input logic valid, input logic sel, input logic [2:0] idx,
                               input logic [15:0] data, input logic st);
    wr_valid = valid;
    wr_sel   = sel;
    wr_idx   = idx;
    wr_data  = data;
    start    = st;
  endtask

  task automatic clearModel();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        model_a[r][c] = '0;
        model_b[r][c] = '0;
      end
    end
  endtask

  // Model view: an A write stores row idx, a B write stores column idx.
  task automatic modelWrite(input logic sel, input logic [2:0] idx, input logic [15:0] data);
    if (idx < 3'd4) begin
      for (int k = 0; k < 4; k++) begin
        if (sel) model_b[k][idx] = data[k*4 +: 4];
        else     model_a[idx][k] = data[k*4 +: 4];
      end
    end
  endtask

  function automatic logic [15:0] expLeft(input int t);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      if (t - i >= 0 && t - i < 4) v[i*4 +: 4] = model_a[i][t-i];
    end
    return v;
  endfunction

  function automatic logic [15:0] expTop(input int t);
    logic [15:0] v;
    v = '0;
    for (int j = 0; j < 4; j++) begin
      if (t - j >= 0 && t - j < 4) v[j*4 +: 4] = model_b[t-j][j];
    end
    return v;
  endfunction

  task automatic writeOperand4(input logic sel, input logic [2:0] idx, input logic [15:0] data);
    applyStimulus(1'b1, sel, idx, data, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    modelWrite(sel, idx, data);
  endtask

  // Start from IDLE, optionally with a write on the same edge; returns at
  // the falling edge of feed cycle t = 0.
  task automatic startFeed4(input logic with_write, input logic sel,
                            input logic [2:0] idx, input logic [15:0] data);
    applyStimulus(with_write, sel, idx, data, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    if (with_write) modelWrite(sel, idx, data);
  endtask

  // Checks the whole feed, the DONE pulse and the return to IDLE. With poke
  // set, a B column write and a repeated start are held during FEED/DONE.
  task automatic runFeed4(input string tag, input logic poke);
    for (int t = 0; t < FL4; t++) begin
      checkOutput($sformatf("%s_left_t%0d", tag, t), left_out, expLeft(t));
      checkOutput($sformatf("%s_top_t%0d", tag, t), top_out, expTop(t));
      checkOutput($sformatf("%s_valid_t%0d", tag, t), feed_valid, 1'b1);
      checkOutput($sformatf("%s_busy_t%0d", tag, t), busy, 1'b1);
      checkOutput($sformatf("%s_ready_t%0d", tag, t), wr_ready, 1'b0);
      checkOutput($sformatf("%s_done_t%0d", tag, t), done, 1'b0);
      if (poke && t == 0) applyStimulus(1'b1, 1'b1, 3'd1, 16'hFFFF, 1'b1);
      if (t < FL4 - 1) tick();
    end
    tick();
    checkOutput({tag, "_done_pulse"}, done, 1'b1);
    checkOutput({tag, "_done_valid"}, feed_valid, 1'b0);
    checkOutput({tag, "_done_busy"}, busy, 1'b0);
    checkOutput({tag, "_done_left"}, left_out, 16'h0);
    checkOutput({tag, "_done_top"}, top_out, 16'h0);
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    tick();
    checkOutput({tag, "_idle_done"}, done, 1'b0);
    checkOutput({tag, "_idle_ready"}, wr_ready, 1'b1);
    if (poke) begin
      tick();
      checkOutput({tag, "_no_second_done"}, done, 1'b0);
      checkOutput({tag, "_no_queued_start"}, busy, 1'b0);
    end
  endtask

  task automatic d2Write(input logic sel, input logic [2:0] idx, input logic [7:0] data);
    d2_wr_valid = 1'b1;
    d2_wr_sel   = sel;
    d2_wr_idx   = idx;
    d2_wr_data  = data;
    tick();
    d2_wr_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_l2 [4];
    logic [7:0] exp_t2 [4];
    exp_l2 = '{8'h01, 8'h32, 8'h40, 8'h00};
    exp_t2 = '{8'h05, 8'h67, 8'h80, 8'h00};

    rst_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    d2_wr_valid = 1'b0; d2_wr_sel = 1'b0; d2_wr_idx = '0; d2_wr_data = '0; d2_start = 1'b0;
    clearModel();

    // Reset values before any clock edge.
    #2;
    checkOutput("rst_ready", wr_ready, 1'b1);
    checkOutput("rst_left", left_out, 16'h0);
    checkOutput("rst_top", top_out, 16'h0);
    checkOutput("rst_valid", feed_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_d2_ready", d2_wr_ready, 1'b1);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Buffers start cleared: a feed with no writes is all zeros.
    startFeed4(1'b0, 1'b0, 3'd0, 16'h0);
    runFeed4("zero", 1'b0);

    // N=2 directed wavefront.
    d2Write(1'b0, 3'd0, 8'h21);
    d2Write(1'b0, 3'd1, 8'h43);
    d2Write(1'b1, 3'd0, 8'h75);
    d2Write(1'b1, 3'd1, 8'h86);
    d2_start = 1'b1;
    tick();
    d2_start = 1'b0;
    for (int t = 0; t < 4; t++) begin
      checkOutput($sformatf("n2_left_t%0d", t), d2_left, exp_l2[t]);
      checkOutput($sformatf("n2_top_t%0d", t), d2_top, exp_t2[t]);
      checkOutput($sformatf("n2_valid_t%0d", t), d2_feed_valid, 1'b1);
      checkOutput($sformatf("n2_done_t%0d", t), d2_done, 1'b0);
      tick();
    end
    checkOutput("n2_done_pulse", d2_done, 1'b1);
    checkOutput("n2_done_valid", d2_feed_valid, 1'b0);
    tick();
    checkOutput("n2_done_clear", d2_done, 1'b0);

    // N=2 write and start on the same edge: new row 0 is in the feed.
    d2_wr_valid = 1'b1; d2_wr_sel = 1'b0; d2_wr_idx = 3'd0; d2_wr_data = 8'h99;
    d2_start = 1'b1;
    tick();
    d2_wr_valid = 1'b0;
    d2_start = 1'b0;
    checkOutput("n2_collide_t0", d2_left, 8'h09);
    tick();
    checkOutput("n2_collide_t1", d2_left, 8'h39);
    tick();
    tick();
    tick();
    checkOutput("n2_collide_done", d2_done, 1'b1);

    // Random operands, two rounds.
    for (int round = 0; round < 2; round++) begin
      for (int r = 0; r < 4; r++) begin
        writeOperand4(1'b0, 3'(r), 16'($urandom));
        writeOperand4(1'b1, 3'(r), 16'($urandom));
      end
      startFeed4(1'b0, 1'b0, 3'd0, 16'h0);
      runFeed4($sformatf("rand%0d", round), 1'b0);
    end

    // Write committed on the start edge.
    startFeed4(1'b1, 1'($urandom), 3'($urandom_range(3, 0)), 16'($urandom));
    runFeed4("collide", 1'b0);

    // Writes and start while busy are ignored; B must be unchanged after.
    startFeed4(1'b0, 1'b0, 3'd0, 16'h0);
    runFeed4("busy", 1'b1);
    startFeed4(1'b0, 1'b0, 3'd0, 16'h0);
    runFeed4("after_busy", 1'b0);

    // Out-of-range indices are dropped; two back-to-back replays.
    writeOperand4(1'b0, 3'd5, 16'($urandom));
    writeOperand4(1'b1, 3'd5, 16'($urandom));
    writeOperand4(1'b0, 3'd4, 16'($urandom));
    startFeed4(1'b0, 1'b0, 3'd0, 16'h0);
    runFeed4("replay_a", 1'b0);
    startFeed4(1'b0, 1'b0, 3'd0, 16'h0);
    runFeed4("replay_b", 1'b0);

    // Reset at t = 2 of a feed: immediate clear, no done, zeroed buffers.
    startFeed4(1'b0, 1'b0, 3'd0, 16'h0);
    tick();
    tick();
    checkOutput("midrst_pre_left", left_out, expLeft(2));
    rst_i = 1'b1;
    #1;
    checkOutput("midrst_left", left_out, 16'h0);
    checkOutput("midrst_top", top_out, 16'h0);
    checkOutput("midrst_valid", feed_valid, 1'b0);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_done", done, 1'b0);
    checkOutput("midrst_ready", wr_ready, 1'b1);
    @(negedge clk_i);
    rst_i = 1'b0;
    clearModel();
    for (int c = 0; c < 12; c++) begin
      tick();
      checkOutput($sformatf("midrst_no_done_c%0d", c), done, 1'b0);
    end
    startFeed4(1'b0, 1'b0, 3'd0, 16'h0);
    runFeed4("post_rst", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
